wave_gen: RTL

Programmable square-wave generator for the chip-tester stimulus path: the transmitting counterpart of the frequency counter, producing the wave that the counter measures. Holds eight 16-bit segment lengths in clock cycles, even entries high and odd entries low, and plays them out on one output pin. Runs either one-shot (one pass of all eight segments) or looping. The segment table is writable at any time.

---
 rtl/wave_gen_pkg.sv | 15 +
 rtl/wave_gen_table.sv | 34 +++
 rtl/wave_gen.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/wave_gen_pkg.sv
// Shared types and defaults for the wave_gen square-wave generator.
// The optional pass counter is enabled by defining WAVE_GEN_PASS_COUNT_EN.
package wave_gen_pkg;

  localparam int DEPTH_DEF = 8;
  localparam int WIDTH_DEF = 16;

  typedef logic [WIDTH_DEF-1:0] seg_t;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } wg_state_t;

endpackage

// File: rtl/wave_gen_table.sv
// Segment-length register file: async clear, one synchronous write port,
// one combinational read port.
module wave_gen_table
  import wave_gen_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int WIDTH = WIDTH_DEF,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             Clock,
  input  logic             nReset,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_r [DEPTH];

  // Table storage; a write lands at the edge and is readable right after it.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
    end else if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/wave_gen.sv
// Programmable square-wave generator: plays DEPTH segment lengths as
// alternating high/low levels, one-shot or looping. WAVE_GEN_PASS_COUNT_EN adds pass_cnt.
module wave_gen
  import wave_gen_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int WIDTH = WIDTH_DEF,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             Clock,
  input  logic             nReset,
  input  logic             load_en,
  input  logic [AW-1:0]    load_addr,
  input  logic [WIDTH-1:0] load_data,
  input  logic             loop,
  input  logic             start,
  input  logic             stop,
  output logic             out_wave,
  output logic             busy,
  output logic             done,
  output logic [AW-1:0]    seg_idx
`ifdef WAVE_GEN_PASS_COUNT_EN
  ,
  output logic [WIDTH-1:0] pass_cnt
`endif
);

  localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);
  localparam logic [AW-1:0]    IDX_ONE  = AW'(1);
  localparam logic [AW-1:0]    IDX_LAST = AW'(DEPTH - 1);

  wg_state_t        state_r, state_nxt_s;
  logic [WIDTH-1:0] cnt_r, cnt_nxt_s;
  logic [AW-1:0]    idx_r, idx_nxt_s;
  logic             loop_r, loop_nxt_s;
  logic             out_wave_r, busy_r, done_r, done_nxt_s;
  logic [AW-1:0]    raddr_s;
  logic [WIDTH-1:0] rdata_s;

  // While running, the read port always looks at the entry to load next;
  // index arithmetic wraps naturally because DEPTH is a power of two.
  assign raddr_s = (state_r == RUN) ? (idx_r + IDX_ONE) : {AW{1'b0}};

  wave_gen_table #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_table (
    .Clock  (Clock),
    .nReset (nReset),
    .we     (load_en),
    .waddr  (load_addr),
    .wdata  (load_data),
    .raddr  (raddr_s),
    .rdata  (rdata_s)
  );

  // Next-state, counter and index logic; a zero entry counts through the wrap.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    idx_nxt_s   = idx_r;
    loop_nxt_s  = loop_r;
    done_nxt_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (start && !stop) begin
          state_nxt_s = RUN;
          idx_nxt_s   = {AW{1'b0}};
          cnt_nxt_s   = rdata_s;
          loop_nxt_s  = loop;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RUN: begin
        if (stop) begin
          state_nxt_s = IDLE;
          idx_nxt_s   = {AW{1'b0}};
        end else if (cnt_r == CNT_ONE) begin
          idx_nxt_s = idx_r + IDX_ONE;
          cnt_nxt_s = rdata_s;
          if ((idx_r == IDX_LAST) && !loop_r) begin
            state_nxt_s = IDLE;
            done_nxt_s  = 1'b1;
          end else begin
            state_nxt_s = RUN;
          end
        end else begin
          cnt_nxt_s = cnt_r - CNT_ONE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        idx_nxt_s   = {AW{1'b0}};
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state_r    <= IDLE;
      cnt_r      <= {WIDTH{1'b0}};
      idx_r      <= {AW{1'b0}};
      loop_r     <= 1'b0;
      out_wave_r <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      cnt_r      <= cnt_nxt_s;
      idx_r      <= idx_nxt_s;
      loop_r     <= loop_nxt_s;
      out_wave_r <= (state_nxt_s == RUN) && !idx_nxt_s[0];
      busy_r     <= (state_nxt_s == RUN);
      done_r     <= done_nxt_s;
    end
  end

  assign out_wave = out_wave_r;
  assign busy     = busy_r;
  assign done     = done_r;
  assign seg_idx  = idx_r;

`ifdef WAVE_GEN_PASS_COUNT_EN
  logic [WIDTH-1:0] pass_cnt_r;
  logic             pass_end_s;
  logic             start_acc_s;

  assign start_acc_s = (state_r == IDLE) && start && !stop;
  assign pass_end_s  = (state_r == RUN) && !stop && (cnt_r == CNT_ONE) && (idx_r == IDX_LAST);

  // Completed-pass counter, restarted on each accepted start.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      pass_cnt_r <= {WIDTH{1'b0}};
    end else if (start_acc_s) begin
      pass_cnt_r <= {WIDTH{1'b0}};
    end else if (pass_end_s) begin
      pass_cnt_r <= pass_cnt_r + CNT_ONE;
    end
  end

  assign pass_cnt = pass_cnt_r;
`endif

endmodule
